// File: rtl/lsu_dccm_wrarb_if.sv
// Write-port request/grant bundle between the LSU write sources and the DCCM write arbiter.
// The arbiter takes the slave modport; the sources and the DCCM side take the master modport.
interface lsu_dccm_wrarb_if #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
);
  logic                        sb_req;
  logic [DCCM_BITS-1:0]        sb_addr;
  logic [DCCM_FDATA_WIDTH-1:0] sb_wdata;
  logic                        sb_grant;

  logic                        dma_req;
  logic [DCCM_BITS-1:0]        dma_addr;
  logic [DCCM_FDATA_WIDTH-1:0] dma_wdata;
  logic                        dma_grant;

  logic                        dccm_wren;
  logic [DCCM_BITS-1:0]        dccm_wr_addr;
  logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data;

  modport master (
    output sb_req, sb_addr, sb_wdata, dma_req, dma_addr, dma_wdata,
    input  sb_grant, dma_grant, dccm_wren, dccm_wr_addr, dccm_wr_data
  );

  modport slave (
    input  sb_req, sb_addr, sb_wdata, dma_req, dma_addr, dma_wdata,
    output sb_grant, dma_grant, dccm_wren, dccm_wr_addr, dccm_wr_data
  );
endinterface

// File: rtl/lsu_dccm_wrarb.sv
// DCCM write-port arbiter: ECC correction buffer, DMA and store buffer compete for the single
// write port, avoiding banks used by the DC1 load, with store-buffer starvation protection.
module lsu_dccm_wrarb #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39,
  parameter int DCCM_WIDTH_BITS  = 2,
  parameter int DCCM_BANK_BITS   = 1,
  parameter int STARVE_MAX       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        freeze,
  input  logic                        ld_rden_dc1,
  input  logic [DCCM_BITS-1:0]        ld_addr_lo_dc1,
  input  logic [DCCM_BITS-1:0]        ld_addr_hi_dc1,
  input  logic                        ecc_err_vld,
  input  logic [DCCM_BITS-1:0]        ecc_err_addr,
  input  logic [DCCM_FDATA_WIDTH-1:0] ecc_corr_data,
  output logic                        ecc_pend,
  output logic                        ecc_drop,
  output logic                        ld_block_dc1,
  lsu_dccm_wrarb_if.slave             bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {
    ECC_IDLE,
    ECC_PEND
  } ecc_state_e;

  typedef logic [DCCM_BANK_BITS-1:0] bank_t;

  function automatic bank_t bank_of(input logic [DCCM_BITS-1:0] a);
    return a[DCCM_WIDTH_BITS +: DCCM_BANK_BITS];
  endfunction

  ecc_state_e                  state_q, state_d;
  logic [DCCM_BITS-1:0]        ecc_addr_q, ecc_addr_d;
  logic [DCCM_FDATA_WIDTH-1:0] ecc_data_q, ecc_data_d;
  logic [3:0]                  starve_q, starve_d;
  logic                        ld_block_q;

  bank_t bank_lo, bank_hi;
  logic  load_live;
  logic  hit_sb, hit_dma, hit_ecc;
  logic  el_sb, el_dma, el_ecc;
  logic  sb_gnt, dma_gnt, ecc_gnt;
  logic  starved;
  logic  unused_addr_bits;

  // Address bits outside the bank field only matter to the load itself.
  assign unused_addr_bits = ^{ld_addr_lo_dc1, ld_addr_hi_dc1};

  assign bank_lo   = bank_of(ld_addr_lo_dc1);
  assign bank_hi   = bank_of(ld_addr_hi_dc1);
  // While blocking, the LSU keeps DC1 loads off the port, so no conflict can exist.
  assign load_live = ld_rden_dc1 & ~ld_block_q;

  assign hit_sb  = load_live & ((bank_of(bus.sb_addr)  == bank_lo) | (bank_of(bus.sb_addr)  == bank_hi));
  assign hit_dma = load_live & ((bank_of(bus.dma_addr) == bank_lo) | (bank_of(bus.dma_addr) == bank_hi));
  assign hit_ecc = load_live & ((bank_of(ecc_addr_q)   == bank_lo) | (bank_of(ecc_addr_q)   == bank_hi));

  assign el_sb  = ~rst & ~freeze & bus.sb_req  & ~hit_sb;
  assign el_dma = ~rst & ~freeze & bus.dma_req & ~hit_dma;
  assign el_ecc = ~rst & ~freeze & (state_q == ECC_PEND) & ~hit_ecc;

  assign starved = (starve_q == STARVE_LIM);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    sb_gnt  = 1'b0;
    dma_gnt = 1'b0;
    ecc_gnt = 1'b0;
    if (starved && el_sb) sb_gnt  = 1'b1;
    else if (el_ecc)      ecc_gnt = 1'b1;
    else if (el_dma)      dma_gnt = 1'b1;
    else if (el_sb)       sb_gnt  = 1'b1;
  end

  always_comb begin
    bus.dccm_wr_addr = '0;
    bus.dccm_wr_data = '0;
    if (ecc_gnt) begin
      bus.dccm_wr_addr = ecc_addr_q;
      bus.dccm_wr_data = ecc_data_q;
    end else if (dma_gnt) begin
      bus.dccm_wr_addr = bus.dma_addr;
      bus.dccm_wr_data = bus.dma_wdata;
    end else if (sb_gnt) begin
      bus.dccm_wr_addr = bus.sb_addr;
      bus.dccm_wr_data = bus.sb_wdata;
    end
  end

  assign bus.sb_grant  = sb_gnt;
  assign bus.dma_grant = dma_gnt;
  assign bus.dccm_wren = sb_gnt | dma_gnt | ecc_gnt;

  // Correction buffer: a new error is only lost when the old entry cannot drain this cycle.
  always_comb begin
    state_d    = state_q;
    ecc_addr_d = ecc_addr_q;
    ecc_data_d = ecc_data_q;
    ecc_drop   = 1'b0;
    case (state_q)
      ECC_IDLE: begin
        if (ecc_err_vld) begin
          state_d    = ECC_PEND;
          ecc_addr_d = ecc_err_addr;
          ecc_data_d = ecc_corr_data;
        end
      end
      ECC_PEND: begin
        if (ecc_gnt) begin
          if (ecc_err_vld) begin
            ecc_addr_d = ecc_err_addr;
            ecc_data_d = ecc_corr_data;
          end else begin
            state_d = ECC_IDLE;
          end
        end else if (ecc_err_vld) begin
          ecc_drop = ~rst;
        end
      end
      default: state_d = ECC_IDLE;
    endcase
  end

  assign ecc_pend = (state_q == ECC_PEND) & ~rst;

  always_comb begin
    starve_d = starve_q;
    if (freeze)                     starve_d = starve_q;
    else if (!bus.sb_req || sb_gnt) starve_d = 4'd0;
    else if (!starved)              starve_d = starve_q + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the correction buffer is reset too, so a discarded entry never leaves stale data behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ECC_IDLE;
      ecc_addr_q <= '0;
      ecc_data_q <= '0;
      starve_q   <= 4'd0;
      ld_block_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ecc_addr_q <= ecc_addr_d;
      ecc_data_q <= ecc_data_d;
      starve_q   <= starve_d;
      ld_block_q <= (starve_d == STARVE_LIM);
    end
  end

  assign ld_block_dc1 = ld_block_q;

endmodule

// File: tb/tb_lsu_dccm_wrarb.sv
// Self-checking bench for lsu_dccm_wrarb: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the arbitration rules.
module tb_lsu_dccm_wrarb;
  localparam int AW   = 16;
  localparam int DW   = 39;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst, freeze, ld_rden_dc1;
  logic [AW-1:0] ld_addr_lo_dc1, ld_addr_hi_dc1;
  logic          ecc_err_vld;
  logic [AW-1:0] ecc_err_addr;
  logic [DW-1:0] ecc_corr_data;
  logic          ecc_pend, ecc_drop, ld_block_dc1;

  lsu_dccm_wrarb_if #(.DCCM_BITS(AW), .DCCM_FDATA_WIDTH(DW)) bus ();

  lsu_dccm_wrarb #(
    .DCCM_BITS(AW), .DCCM_FDATA_WIDTH(DW), .DCCM_WIDTH_BITS(2),
    .DCCM_BANK_BITS(1), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .ld_rden_dc1(ld_rden_dc1),
    .ld_addr_lo_dc1(ld_addr_lo_dc1), .ld_addr_hi_dc1(ld_addr_hi_dc1),
    .ecc_err_vld(ecc_err_vld), .ecc_err_addr(ecc_err_addr), .ecc_corr_data(ecc_corr_data),
    .ecc_pend(ecc_pend), .ecc_drop(ecc_drop), .ld_block_dc1(ld_block_dc1),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit            m_pend;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_starve;
  bit            m_block;

  typedef struct packed {
    logic          sb, dma, wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          pend, drop, block;
  } exp_t;

  function automatic int bank_of(input logic [AW-1:0] a);
    return (int'(a) / 4) % 2;
  endfunction

  function automatic bit hits_load(input logic [AW-1:0] a);
    return (ld_rden_dc1 === 1'b1) && !m_block &&
           (bank_of(a) == bank_of(ld_addr_lo_dc1) || bank_of(a) == bank_of(ld_addr_hi_dc1));
  endfunction

  // Expected outputs for the current inputs, plus whether the ECC entry drains.
  function automatic exp_t model_eval(output bit ecc_go);
    exp_t e;
    bit ok_sb, ok_dma, ok_ecc;
    e = '0;
    ecc_go = 0;
    e.block = m_block;
    if (rst) return e;
    ok_sb  = bus.sb_req  && !freeze && !hits_load(bus.sb_addr);
    ok_dma = bus.dma_req && !freeze && !hits_load(bus.dma_addr);
    ok_ecc = m_pend      && !freeze && !hits_load(m_addr);
    if (m_starve == SMAX && ok_sb) e.sb = 1;
    else if (ok_ecc)               ecc_go = 1;
    else if (ok_dma)               e.dma = 1;
    else if (ok_sb)                e.sb = 1;
    e.wren = e.sb | e.dma | ecc_go;
    if (ecc_go)     begin e.addr = m_addr;       e.data = m_data;        end
    else if (e.dma) begin e.addr = bus.dma_addr; e.data = bus.dma_wdata; end
    else if (e.sb)  begin e.addr = bus.sb_addr;  e.data = bus.sb_wdata;  end
    e.pend = m_pend;
    e.drop = m_pend && !ecc_go && ecc_err_vld;
    return e;
  endfunction

  // Update the model with the current inputs, then move to just after the next rising edge.
  task automatic advance();
    exp_t e;
    bit ecc_go;
    int s_next;
    e = model_eval(ecc_go);
    if (rst) begin
      m_pend = 0; m_addr = '0; m_data = '0; m_starve = 0; m_block = 0;
    end else begin
      if (ecc_err_vld && (!m_pend || ecc_go)) begin
        m_pend = 1; m_addr = ecc_err_addr; m_data = ecc_corr_data;
      end else if (m_pend && ecc_go) begin
        m_pend = 0;
      end
      if (freeze)                    s_next = m_starve;
      else if (!bus.sb_req || e.sb)  s_next = 0;
      else                           s_next = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
      m_starve = s_next;
      m_block  = (s_next == SMAX);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 0; freeze = 0; ld_rden_dc1 = 0; ld_addr_lo_dc1 = '0; ld_addr_hi_dc1 = '0;
    ecc_err_vld = 0; ecc_err_addr = '0; ecc_corr_data = '0;
    bus.sb_req = 0; bus.sb_addr = '0; bus.sb_wdata = '0;
    bus.dma_req = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1; bus.sb_req = 1; bus.dma_req = 1; ecc_err_vld = 1;
    bus.sb_addr = 16'h0010; bus.dma_addr = 16'h0020; ecc_err_addr = 16'h0030;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.sb_grant !== 1'b0) begin errors++; $display("FAIL rst_sb_grant got %b want 0", bus.sb_grant); end
      checks++; if (bus.dma_grant !== 1'b0) begin errors++; $display("FAIL rst_dma_grant got %b want 0", bus.dma_grant); end
      checks++; if (bus.dccm_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b want 0", bus.dccm_wren); end
      checks++; if (ecc_pend !== 1'b0) begin errors++; $display("FAIL rst_pend got %b want 0", ecc_pend); end
      checks++; if (ecc_drop !== 1'b0) begin errors++; $display("FAIL rst_drop got %b want 0", ecc_drop); end
      checks++; if (ld_block_dc1 !== 1'b0) begin errors++; $display("FAIL rst_block got %b want 0", ld_block_dc1); end
      advance();
    end
    quiet();
    @(negedge clk);
    checks++; if (ecc_pend !== 1'b0) begin errors++; $display("FAIL post_rst_pend got %b want 0", ecc_pend); end
    advance();
  endtask

  task automatic test_idle_port();
    bus.sb_req = 1; bus.sb_addr = 16'h0010; bus.sb_wdata = 39'h12_3456_789A;
    @(negedge clk);
    checks++; if (bus.sb_grant !== 1'b1) begin errors++; $display("FAIL idle_grant got %b want 1", bus.sb_grant); end
    checks++; if (bus.dccm_wren !== 1'b1) begin errors++; $display("FAIL idle_wren got %b want 1", bus.dccm_wren); end
    checks++; if (bus.dccm_wr_addr !== 16'h0010) begin errors++; $display("FAIL idle_addr got %h want 0010", bus.dccm_wr_addr); end
    checks++; if (bus.dccm_wr_data !== 39'h12_3456_789A) begin errors++; $display("FAIL idle_data got %h want 123456789a", bus.dccm_wr_data); end
    advance();
    bus.sb_req = 0;
    @(negedge clk);
    checks++; if (bus.dccm_wr_addr !== 16'h0000 || bus.dccm_wren !== 1'b0) begin errors++; $display("FAIL idle_quiet got wren=%b addr=%h want 0/0000", bus.dccm_wren, bus.dccm_wr_addr); end
    advance();
  endtask

  task automatic test_conflict();
    bus.sb_req = 1; bus.sb_addr = 16'h0004; bus.sb_wdata = 39'h0A_0000_0004;
    ld_rden_dc1 = 1; ld_addr_lo_dc1 = 16'h0104; ld_addr_hi_dc1 = 16'h0104;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if (bus.sb_grant !== 1'b0 || bus.dccm_wren !== 1'b0) begin errors++; $display("FAIL conflict_nogrant cyc %0d got grant=%b wren=%b want 0/0", i, bus.sb_grant, bus.dccm_wren); end
      checks++; if (ld_block_dc1 !== 1'b0) begin errors++; $display("FAIL conflict_block_early cyc %0d got %b want 0", i, ld_block_dc1); end
      advance();
    end
    ld_rden_dc1 = 0;
    @(negedge clk);
    checks++; if (ld_block_dc1 !== 1'b1) begin errors++; $display("FAIL conflict_block cyc 5 got %b want 1", ld_block_dc1); end
    checks++; if (bus.sb_grant !== 1'b1 || bus.dccm_wr_addr !== 16'h0004) begin errors++; $display("FAIL conflict_grant got grant=%b addr=%h want 1/0004", bus.sb_grant, bus.dccm_wr_addr); end
    advance();
    bus.sb_req = 0;
    @(negedge clk);
    checks++; if (ld_block_dc1 !== 1'b0) begin errors++; $display("FAIL conflict_unblock got %b want 0", ld_block_dc1); end
    advance();
  endtask

  task automatic test_priority();
    ecc_err_vld = 1; ecc_err_addr = 16'h0040; ecc_corr_data = 39'h40_4040_4040;
    @(negedge clk);
    checks++; if (ecc_pend !== 1'b0 || ecc_drop !== 1'b0) begin errors++; $display("FAIL prio_capture got pend=%b drop=%b want 0/0", ecc_pend, ecc_drop); end
    advance();
    ecc_err_vld = 0;
    bus.dma_req = 1; bus.dma_addr = 16'h0048; bus.dma_wdata = 39'h48_4848_4848;
    bus.sb_req  = 1; bus.sb_addr  = 16'h0050; bus.sb_wdata  = 39'h50_5050_5050;
    @(negedge clk);
    checks++; if (ecc_pend !== 1'b1) begin errors++; $display("FAIL prio_pend got %b want 1", ecc_pend); end
    checks++; if (bus.dccm_wr_addr !== 16'h0040 || bus.dccm_wr_data !== 39'h40_4040_4040 || bus.dma_grant !== 1'b0 || bus.sb_grant !== 1'b0) begin errors++; $display("FAIL prio_ecc_first got addr=%h dma=%b sb=%b want 0040/0/0", bus.dccm_wr_addr, bus.dma_grant, bus.sb_grant); end
    advance();
    @(negedge clk);
    checks++; if (bus.dma_grant !== 1'b1 || bus.dccm_wr_addr !== 16'h0048 || ecc_pend !== 1'b0) begin errors++; $display("FAIL prio_dma_second got dma=%b addr=%h pend=%b want 1/0048/0", bus.dma_grant, bus.dccm_wr_addr, ecc_pend); end
    advance();
    bus.dma_req = 0;
    @(negedge clk);
    checks++; if (bus.sb_grant !== 1'b1 || bus.dccm_wr_addr !== 16'h0050) begin errors++; $display("FAIL prio_sb_third got sb=%b addr=%h want 1/0050", bus.sb_grant, bus.dccm_wr_addr); end
    advance();
    bus.sb_req = 0;
  endtask

  task automatic test_collision();
    ecc_err_vld = 1; ecc_err_addr = 16'h0020; ecc_corr_data = 39'h20_2020_2020;
    advance();
    ecc_err_addr = 16'h0030; ecc_corr_data = 39'h30_3030_3030;
    ld_rden_dc1 = 1; ld_addr_lo_dc1 = 16'h0000; ld_addr_hi_dc1 = 16'h0000;
    @(negedge clk);
    checks++; if (ecc_drop !== 1'b1 || bus.dccm_wren !== 1'b0) begin errors++; $display("FAIL coll_drop got drop=%b wren=%b want 1/0", ecc_drop, bus.dccm_wren); end
    advance();
    ecc_err_vld = 0; ld_rden_dc1 = 0;
    @(negedge clk);
    checks++; if (ecc_drop !== 1'b0) begin errors++; $display("FAIL coll_drop_pulse got %b want 0", ecc_drop); end
    checks++; if (bus.dccm_wren !== 1'b1 || bus.dccm_wr_addr !== 16'h0020 || bus.dccm_wr_data !== 39'h20_2020_2020) begin errors++; $display("FAIL coll_old_write got wren=%b addr=%h want 1/0020", bus.dccm_wren, bus.dccm_wr_addr); end
    advance();
  endtask

  task automatic test_swap();
    ecc_err_vld = 1; ecc_err_addr = 16'h0060; ecc_corr_data = 39'h60_6060_6060;
    advance();
    ecc_err_addr = 16'h0070; ecc_corr_data = 39'h70_7070_7070;
    @(negedge clk);
    checks++; if (bus.dccm_wr_addr !== 16'h0060 || bus.dccm_wr_data !== 39'h60_6060_6060 || ecc_drop !== 1'b0) begin errors++; $display("FAIL swap_old_write got addr=%h drop=%b want 0060/0", bus.dccm_wr_addr, ecc_drop); end
    advance();
    ecc_err_vld = 0;
    @(negedge clk);
    checks++; if (ecc_pend !== 1'b1 || bus.dccm_wr_addr !== 16'h0070 || bus.dccm_wr_data !== 39'h70_7070_7070) begin errors++; $display("FAIL swap_new_entry got pend=%b addr=%h want 1/0070", ecc_pend, bus.dccm_wr_addr); end
    advance();
    @(negedge clk);
    checks++; if (ecc_pend !== 1'b0 || bus.dccm_wren !== 1'b0) begin errors++; $display("FAIL swap_drain got pend=%b wren=%b want 0/0", ecc_pend, bus.dccm_wren); end
    advance();
  endtask

  task automatic test_freeze_reset();
    ecc_err_vld = 1; ecc_err_addr = 16'h0080; ecc_corr_data = 39'h08_0808_0808;
    advance();
    ecc_err_vld = 0; freeze = 1;
    bus.sb_req = 1;  bus.sb_addr = 16'h00A0;  bus.sb_wdata = 39'h0A;
    bus.dma_req = 1; bus.dma_addr = 16'h00B0; bus.dma_wdata = 39'h0B;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (bus.dccm_wren !== 1'b0 || ld_block_dc1 !== 1'b0) begin errors++; $display("FAIL frz_hold cyc %0d got wren=%b block=%b want 0/0", i, bus.dccm_wren, ld_block_dc1); end
      advance();
    end
    freeze = 0;
    @(negedge clk);
    checks++; if (bus.dccm_wr_addr !== 16'h0080 || bus.sb_grant !== 1'b0) begin errors++; $display("FAIL frz_release got addr=%h sb=%b want 0080/0", bus.dccm_wr_addr, bus.sb_grant); end
    advance();
    advance();
    bus.dma_req = 0;
    advance();
    bus.sb_req = 0;
    ecc_err_vld = 1; ecc_err_addr = 16'h0090; ecc_corr_data = 39'h09_0909_0909;
    advance();
    ecc_err_vld = 0; rst = 1;
    @(negedge clk);
    checks++; if (ecc_pend !== 1'b0 || bus.dccm_wren !== 1'b0) begin errors++; $display("FAIL rstpend_now got pend=%b wren=%b want 0/0", ecc_pend, bus.dccm_wren); end
    advance();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ecc_pend !== 1'b0 || bus.dccm_wren !== 1'b0) begin errors++; $display("FAIL rstpend_after cyc %0d got pend=%b wren=%b want 0/0", i, ecc_pend, bus.dccm_wren); end
      advance();
    end
  endtask

  task automatic test_random();
    exp_t e, o;
    bit ecc_go;
    quiet();
    for (int i = 0; i < 800; i++) begin
      rst    = ($urandom_range(99) == 0);
      freeze = ($urandom_range(9) == 0);
      ld_rden_dc1 = m_block ? 1'b0 : 1'($urandom_range(1));
      ld_addr_lo_dc1 = 16'($urandom);
      ld_addr_hi_dc1 = ld_addr_lo_dc1 + 16'($urandom_range(7));
      ecc_err_vld   = ($urandom_range(4) == 0);
      ecc_err_addr  = 16'($urandom);
      ecc_corr_data = DW'({$urandom, $urandom});
      if (!bus.sb_req) begin
        bus.sb_req = 1'($urandom_range(1)); bus.sb_addr = 16'($urandom); bus.sb_wdata = DW'({$urandom, $urandom});
      end
      if (!bus.dma_req) begin
        bus.dma_req = ($urandom_range(3) == 0); bus.dma_addr = 16'($urandom); bus.dma_wdata = DW'({$urandom, $urandom});
      end
      @(negedge clk);
      e = model_eval(ecc_go);
      o = {bus.sb_grant, bus.dma_grant, bus.dccm_wren, bus.dccm_wr_addr, bus.dccm_wr_data, ecc_pend, ecc_drop, ld_block_dc1};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rand cyc %0d got sb=%b dma=%b wren=%b addr=%h data=%h pend=%b drop=%b blk=%b want sb=%b dma=%b wren=%b addr=%h data=%h pend=%b drop=%b blk=%b",
                 i, o.sb, o.dma, o.wren, o.addr, o.data, o.pend, o.drop, o.block,
                 e.sb, e.dma, e.wren, e.addr, e.data, e.pend, e.drop, e.block);
      end
      advance();
      if (e.sb)  bus.sb_req  = 0;
      if (e.dma) bus.dma_req = 0;
    end
    quiet();
    advance();
  endtask

  initial begin
    m_pend = 0; m_addr = '0; m_data = '0; m_starve = 0; m_block = 0;
    quiet();
    rst = 1;
    test_reset();
    test_idle_port();
    test_conflict();
    test_priority();
    test_collision();
    test_swap();
    test_freeze_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_dccm_wrarb.md
LSU_DCCM_WRARB -- requirements
Module: lsu_dccm_wrarb

Interface
REQ-001 SHALL have parameter DCCM_BITS, default 16, DCCM byte-address width.
REQ-002 SHALL have parameter DCCM_FDATA_WIDTH, default 39, data plus ECC width.
REQ-003 SHALL have parameter DCCM_WIDTH_BITS, default 2, LSB of the bank-select field.
REQ-004 SHALL have parameter DCCM_BANK_BITS, default 1, width of the bank-select field.
REQ-005 SHALL have parameter STARVE_MAX, default 4, store-buffer starvation threshold, range 1..15.
REQ-006 SHALL have ports as listed below:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- freeze  in  1  LSU freeze; blocks all grants.
- ld_rden_dc1  in  1  DC1 load read uses the port this cycle.
- ld_addr_lo_dc1, ld_addr_hi_dc1  in  DCCM_BITS each  load start and end addresses.
- sb_req  in  1  store-buffer write request.
- sb_addr  in  DCCM_BITS  store-buffer write address.
- sb_wdata  in  DCCM_FDATA_WIDTH  store-buffer write data.
- sb_grant  out  1  store-buffer write granted.
- dma_req  in  1  DMA write request.
- dma_addr  in  DCCM_BITS  DMA write address.
- dma_wdata  in  DCCM_FDATA_WIDTH  DMA write data.
- dma_grant  out  1  DMA write granted.
- ecc_err_vld  in  1  DC3 single-bit ECC error detected; one-cycle pulse.
- ecc_err_addr  in  DCCM_BITS  address of the corrupted word.
- ecc_corr_data  in  DCCM_FDATA_WIDTH  corrected data plus ECC.
- ecc_pend  out  1  correction write-back buffer occupied.
- ecc_drop  out  1  correction lost because the buffer was full.
- ld_block_dc1  out  1  LSU must not issue a DC1 load next cycle.
- dccm_wren  out  1  DCCM write enable.
- dccm_wr_addr  out  DCCM_BITS  DCCM write address.
- dccm_wr_data  out  DCCM_FDATA_WIDTH  DCCM write data.

Function
REQ-007 SHALL define bank(a) = a[DCCM_WIDTH_BITS +: DCCM_BANK_BITS].
- A writer at address W conflicts iff ld_rden_dc1 & (bank(W)==bank(ld_addr_lo_dc1) | bank(W)==bank(ld_addr_hi_dc1)).
REQ-008 SHALL treat a requester as eligible iff its request is asserted, freeze=0, and it has no conflict.
REQ-009 SHALL grant at most one writer per cycle, combinationally in the request cycle.
REQ-010 SHALL use priority ECC buffer > DMA > store buffer, except while starve_cnt==STARVE_MAX, when the store buffer has top priority.
REQ-011 SHALL drive dccm_wren=|grants, with dccm_wr_addr/dccm_wr_data muxed from the granted source; when idle, addr and data are 0.
REQ-012 SHALL require sb_req/dma_req and their addr/data to be held stable until granted; the block does not latch them.
REQ-013 SHALL implement the ECC buffer FSM with states IDLE and PEND; ecc_pend=(state==PEND).
- IDLE + ecc_err_vld: capture addr/data, go to PEND.
- PEND + grant + no ecc_err_vld: go to IDLE.
- PEND + grant + ecc_err_vld: capture the new error, stay in PEND, no drop.
- PEND + no grant + ecc_err_vld: keep the old entry, ecc_drop=1 for that cycle.
REQ-014 SHALL maintain a 4-bit starve_cnt:
- increment, saturating at STARVE_MAX, when sb_req & ~sb_grant & ~freeze;
- clear on sb_grant or when sb_req=0;
- hold during freeze.
REQ-015 SHALL drive ld_block_dc1=1 as a registered output in the cycle after starve_cnt reaches STARVE_MAX, deasserting the cycle after sb_grant.
REQ-016 SHALL treat any write during ld_block_dc1 as conflict-free, since the LSU guarantees ld_rden_dc1=0 while ld_block_dc1=1.
REQ-017 SHALL produce no grant and no dccm_wren while freeze=1; the ECC buffer still captures.

Reset
REQ-018 SHALL, while rst=1, set FSM=IDLE, starve_cnt=0, ld_block_dc1=0, and buffer contents=0.
- All grants, dccm_wren, ecc_pend and ecc_drop SHALL be 0 regardless of other inputs.
REQ-019 SHALL discard a pending correction when rst asserts mid-PEND; no write issues after reset.

Verification
REQ-020 Idle port: sb_req=1, sb_addr=0x0010, no load -> sb_grant=1, dccm_wren=1, dccm_wr_addr=0x0010 in the same cycle.
REQ-021 Conflict: sb_addr=0x0004, ld_rden_dc1=1, ld_addr_lo=0x0104 (bank 1), held 4 cycles -> no grant; ld_block_dc1=1 in cycle 5; first grant when the load drops; starve_cnt cleared.
REQ-022 Priority: ecc_pend=1, dma_req=1, sb_req=1, no load -> ECC granted first, then DMA, then SB on consecutive cycles.
REQ-023 Collision: PEND at 0x0020, ecc_err_vld at 0x0030 with a port conflict -> ecc_drop=1 for one cycle; the later write goes to 0x0020.
REQ-024 Swap: PEND granted in the same cycle a new ecc_err_vld arrives -> write to the old addr, ecc_pend stays 1 with the new addr, ecc_drop=0.
REQ-025 Freeze/reset: freeze=1 with all requests -> no dccm_wren and starve_cnt held; rst=1 mid-PEND -> ecc_pend=0 next cycle and no write.
